// File: rtl/ctrl_reducao_blocos.sv
// Block-average downscaling sequencer: walks the source frame in FxF blocks (F = 2 or 4),
// accumulates each block and emits its mean. Define ARREDONDAMENTO_EN for round-half-up means.
module ctrl_reducao_blocos #(
    parameter int LARGURA = 160,
    parameter int ALTURA  = 120,
    parameter int ADDR_W  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              fator_sel,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LER      = 3'd1;
    localparam logic [2:0] DRENO    = 3'd2;
    localparam logic [2:0] ESCREVER = 3'd3;
    localparam logic [2:0] FIM      = 3'd4;

    localparam logic [ADDR_W-1:0] LARG_A = ADDR_W'(LARGURA);
    localparam logic [ADDR_W-1:0] ALT_A  = ADDR_W'(ALTURA);

    logic [2:0]        estado;
    logic              f4;
    logic [ADDR_W-1:0] linha;
    logic [ADDR_W-1:0] coluna;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [1:0]        di;
    logic [1:0]        dj;
    logic [11:0]       soma;
    logic              rd_pend;

    logic [ADDR_W-1:0] passo;
    logic [1:0]        lim;
    logic              ultima_col;
    logic              ultima_lin;

    assign passo      = f4 ? ADDR_W'(4) : ADDR_W'(2);
    assign lim        = f4 ? 2'd3 : 2'd1;
    assign ultima_col = (coluna == LARG_A - passo);
    assign ultima_lin = (linha == ALT_A - passo);

    assign busy     = (estado == LER) || (estado == DRENO) || (estado == ESCREVER);
    assign done     = (estado == FIM);
    assign rd_en    = (estado == LER);
    assign wr_valid = (estado == ESCREVER);
    assign wr_addr  = wr_addr_q;
    assign rd_addr  = (linha + ADDR_W'(di)) * LARG_A + coluna + ADDR_W'(dj);

`ifdef ARREDONDAMENTO_EN
    logic [12:0] soma_arred;
    logic [12:0] media_larga;

    assign soma_arred  = {1'b0, soma} + (f4 ? 13'd8 : 13'd2);
    assign media_larga = f4 ? (soma_arred >> 4) : (soma_arred >> 2);
    assign wr_data     = (media_larga > 13'd255) ? 8'hFF : media_larga[7:0];
`else
    // A 2x2 sum never exceeds 1020, so bits [9:2] hold the full quotient.
    assign wr_data = f4 ? soma[11:4] : soma[9:2];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado    <= IDLE;
            f4        <= 1'b0;
            linha     <= '0;
            coluna    <= '0;
            wr_addr_q <= '0;
            di        <= 2'd0;
            dj        <= 2'd0;
            soma      <= 12'd0;
            rd_pend   <= 1'b0;
        end else begin
            rd_pend <= (estado == LER);
            // Pixel arrives one cycle after its read; later case branches take priority.
            if (rd_pend) begin
                soma <= soma + {4'd0, rd_data};
            end
            case (estado)
                IDLE: begin
                    if (start) begin
                        f4        <= fator_sel;
                        linha     <= '0;
                        coluna    <= '0;
                        wr_addr_q <= '0;
                        di        <= 2'd0;
                        dj        <= 2'd0;
                        soma      <= 12'd0;
                        estado    <= LER;
                    end
                end
                LER: begin
                    if (dj == lim) begin
                        dj <= 2'd0;
                        if (di == lim) begin
                            di     <= 2'd0;
                            estado <= DRENO;
                        end else begin
                            di <= di + 2'd1;
                        end
                    end else begin
                        dj <= dj + 2'd1;
                    end
                end
                DRENO: begin
                    estado <= ESCREVER;
                end
                ESCREVER: begin
                    if (wr_ready) begin
                        soma      <= 12'd0;
                        wr_addr_q <= wr_addr_q + ADDR_W'(1);
                        if (ultima_col) begin
                            coluna <= '0;
                            if (ultima_lin) begin
                                linha  <= '0;
                                estado <= FIM;
                            end else begin
                                linha  <= linha + passo;
                                estado <= LER;
                            end
                        end else begin
                            coluna <= coluna + passo;
                            estado <= LER;
                        end
                    end
                end
                FIM: begin
                    estado <= IDLE;
                end
                default: begin
                    estado <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_reducao_blocos.sv
// Self-checking bench for ctrl_reducao_blocos on a 4x4 frame of pixels 1..16, checked against
// a block-mean model; honours ARREDONDAMENTO_EN the same way the design does.
module tb_ctrl_reducao_blocos;

    localparam int LARG = 4;
    localparam int ALT  = 4;
    localparam int AW   = 4;

`ifdef ARREDONDAMENTO_EN
    localparam int L2[4]  = '{4, 6, 12, 14};
    localparam int L4     = 9;
    localparam int LSTALL = 6;
`else
    localparam int L2[4]  = '{3, 5, 11, 13};
    localparam int L4     = 8;
    localparam int LSTALL = 5;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          fator_sel;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data = 8'd0;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    logic [7:0] mem [0:LARG*ALT-1];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int exp_rd[$];
    int exp_wr[$];
    int got_wr[$];
    int wr_idx = 0;
    bit first_seen = 0;
    int first_cyc = 0;
    bit done_seen = 0;
    int done_cyc = 0;
    bit stall_prev = 0;
    int stall_data = 0;
    int stall_addr = 0;

    ctrl_reducao_blocos #(.LARGURA(LARG), .ALTURA(ALT), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .fator_sel(fator_sel),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected reads and block means straight from the frame contents.
    task automatic build_model(input int f);
        int sum;
        int mean;
        exp_rd.delete();
        exp_wr.delete();
        wr_idx = 0;
        for (int by = 0; by < ALT; by += f) begin
            for (int bx = 0; bx < LARG; bx += f) begin
                sum = 0;
                for (int i = 0; i < f; i++) begin
                    for (int j = 0; j < f; j++) begin
                        exp_rd.push_back((by + i) * LARG + bx + j);
                        sum += mem[(by + i) * LARG + bx + j];
                    end
                end
`ifdef ARREDONDAMENTO_EN
                mean = (sum + f * f / 2) / (f * f);
`else
                mean = sum / (f * f);
`endif
                if (mean > 255) mean = 255;
                exp_wr.push_back(mean);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_rd_en", rd_en, 0);
            checkOutput("rst_rd_addr", rd_addr, 0);
            checkOutput("rst_wr_valid", wr_valid, 0);
            checkOutput("rst_wr_addr", wr_addr, 0);
            checkOutput("rst_wr_data", wr_data, 0);
            exp_rd.delete();
            exp_wr.delete();
            wr_idx = 0;
            stall_prev = 0;
        end else begin
            checkOutput("rd_while_wr", rd_en & wr_valid, 0);
            if (rd_en) begin
                if (!first_seen) begin
                    first_seen = 1;
                    first_cyc = cyc;
                end
                checkOutput("reads_pending", exp_rd.size() > 0, 1);
                if (exp_rd.size() > 0) checkOutput("rd_addr", rd_addr, exp_rd.pop_front());
                checkOutput("busy_rd", busy, 1);
            end
            if (stall_prev) begin
                checkOutput("stall_valid", wr_valid, 1);
                checkOutput("stall_data", wr_data, stall_data);
                checkOutput("stall_addr", wr_addr, stall_addr);
            end
            if (wr_valid && wr_ready) begin
                checkOutput("writes_pending", exp_wr.size() > 0, 1);
                if (exp_wr.size() > 0) checkOutput("wr_data", wr_data, exp_wr.pop_front());
                checkOutput("wr_addr", wr_addr, wr_idx);
                wr_idx++;
                got_wr.push_back(int'(wr_data));
                stall_prev = 0;
            end else if (wr_valid) begin
                stall_prev = 1;
                stall_data = wr_data;
                stall_addr = wr_addr;
            end else begin
                stall_prev = 0;
            end
            if (done) begin
                done_seen = 1;
                done_cyc = cyc;
                checkOutput("busy_done", busy, 0);
            end
        end
    end

    task automatic applyStimulus(input logic fs);
        @(posedge clk);
        #1 fator_sel = fs;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic begin_frame(input int f);
        got_wr.delete();
        first_seen = 0;
        done_seen = 0;
        build_model(f);
        applyStimulus(f == 4);
    endtask

    task automatic end_frame(input int exp_lat);
        for (int k = 0; k < 400 && !done_seen; k++) @(posedge clk);
        checkOutput("done_seen", done_seen, 1);
        if (done_seen) checkOutput("done_latency", done_cyc - first_cyc, exp_lat);
        checkOutput("reads_left", exp_rd.size(), 0);
        checkOutput("writes_left", exp_wr.size(), 0);
        @(posedge clk);
        #1 checkOutput("done_pulse", done, 0);
    endtask

    task automatic check_log(input int n, input int l0, input int l1, input int l2, input int l3);
        int lit[4];
        lit = '{l0, l1, l2, l3};
        checkOutput("log_len", got_wr.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < got_wr.size()) checkOutput("log_data", got_wr[i], lit[i]);
        end
    endtask

    initial begin
        bit found;
        for (int i = 0; i < LARG * ALT; i++) mem[i] = 8'(i + 1);
        rst = 1'b1;
        start = 1'b0;
        fator_sel = 1'b0;
        wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] factor 2 frame");
        begin_frame(2);
        end_frame(24);
        check_log(4, L2[0], L2[1], L2[2], L2[3]);

        $display("[TB] factor 4 frame");
        begin_frame(4);
        end_frame(18);
        check_log(1, L4, 0, 0, 0);

        $display("[TB] backpressure on second block");
        begin_frame(2);
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(posedge clk);
            #1 if (wr_valid && wr_addr == 1) found = 1;
        end
        checkOutput("stall_reached", found, 1);
        wr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1 checkOutput("bp_valid", wr_valid, 1);
            checkOutput("bp_data", wr_data, LSTALL);
            checkOutput("bp_addr", wr_addr, 1);
            checkOutput("bp_no_read", rd_en, 0);
        end
        wr_ready = 1'b1;
        end_frame(29);
        check_log(4, L2[0], L2[1], L2[2], L2[3]);

        $display("[TB] start and fator_sel disturbed mid-frame");
        begin_frame(2);
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        fator_sel = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1 fator_sel = ~fator_sel;
        end
        fator_sel = 1'b0;
        end_frame(24);
        check_log(4, L2[0], L2[1], L2[2], L2[3]);
        repeat (10) @(posedge clk);
        #1 checkOutput("no_second_frame", busy, 0);

        $display("[TB] reset during second block");
        begin_frame(2);
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(posedge clk);
            #1 if (rd_en && wr_addr == 1) found = 1;
        end
        checkOutput("abort_point_reached", found, 1);
        #2 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("post_rst_wr_addr", wr_addr, 0);
        begin_frame(2);
        end_frame(24);
        check_log(4, L2[0], L2[1], L2[2], L2[3]);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_reducao_blocos.md
# ctrl_reducao_blocos

Sequencing controller for block-average image downscaling. On a start command it walks a source frame held in an external synchronous RAM in FATOR×FATOR blocks, issues one read per pixel, and accumulates each block. It writes each block mean to a destination memory through a valid/ready port. It sits between the frame buffer read port and the downscaled-frame writer, and makes the 2× and 4× reduction a run-time choice.

## Interface
Parameters:
- LARGURA, 160: source width in pixels; must be a multiple of 4.
- ALTURA, 120: source height in pixels; must be a multiple of 4.
- ADDR_W, 15: address width of the source and destination ports; must satisfy 2^ADDR_W ≥ LARGURA*ALTURA.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: start one frame; sampled only in IDLE.
- fator_sel, in, 1: 0 selects factor 2; 1 selects factor 4. Latched on an accepted start.
- busy, out, 1: high from the cycle after an accepted start until `done`.
- done, out, 1: one-cycle pulse after the last block write is accepted.
- rd_en, out, 1: source read strobe.
- rd_addr, out, ADDR_W: source address, equal to (linha+di)*LARGURA + coluna+dj.
- rd_data, in, 8: source pixel; valid exactly one cycle after rd_en.
- wr_valid, out, 1: a block mean is available.
- wr_ready, in, 1: the destination accepts the mean.
- wr_addr, out, ADDR_W: destination index in row-major block order, starting at 0.
- wr_data, out, 8: the block mean.

## Operation
- States: IDLE, LER, DRENO, ESCREVER, FIM.
- IDLE:
  - start=1 latches F (2 or 4), clears linha/coluna/di/dj/soma/wr_addr, and moves to LER.
  - start=0 stays in IDLE.
- LER:
  - rd_en=1 every cycle; the address follows row-major order inside the block (dj fastest).
  - After F² addresses the state moves to DRENO.
- Accumulation: soma += rd_data on every cycle where rd_en was high in the previous cycle. soma is 12 bits, because 16*255 = 4080.
- DRENO:
  - Lasts one cycle; rd_en=0.
  - The last pixel is accumulated, then the state moves to ESCREVER.
- ESCREVER:
  - wr_valid=1, with wr_data = soma >> log2(F²): shift by 2 for F=2, by 4 for F=4.
  - wr_valid, wr_data and wr_addr hold stable until wr_ready=1.
  - On handshake: soma is cleared, wr_addr is incremented, and the anchor advances.
    - If coluna = LARGURA-F: coluna becomes 0 and linha advances by F. If linha was ALTURA-F, the state moves to FIM.
    - Otherwise coluna advances by F.
  - The next state is LER unless the frame is complete.
- FIM: done=1 for one cycle, then IDLE. busy is 0 in FIM.
- start in any state other than IDLE is ignored; it is not queued.
- fator_sel changes during a frame have no effect.
- Reset mid-frame aborts immediately. No partial write is issued, and the destination contents are left untouched.

## Timing
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, wr_valid=0, wr_addr=0, wr_data=0. State is IDLE and soma=0.
- start=1 at edge n puts the first rd_en high in cycle n+1.
- Per block, with wr_ready held high: F² cycles LER, 1 cycle DRENO, 1 cycle ESCREVER, for F²+2 cycles total (6 for F=2, 18 for F=4).
- Frame with wr_ready held high: (LARGURA*ALTURA/F²)*(F²+2) cycles, plus 1 cycle for FIM.
- No read is issued while wr_valid is high; wr_ready low adds one cycle per stalled cycle.
- wr_valid never deasserts without a handshake, except on reset.

## Configuration
- ARREDONDAMENTO_EN:
  - Defined: wr_data = (soma + F²/2) >> log2(F²), i.e. round-half-up. The addition is 13 bits wide so it cannot overflow; the result saturates at 255 (not reachable for 8-bit inputs).
  - Undefined: truncation, wr_data = soma >> log2(F²).
  - Timing is identical in both builds.

## Test plan
All scenarios use LARGURA=4, ALTURA=4, source pixels 1..16 in row-major order, and wr_ready=1 unless stated.
- F=2 without the macro -> writes (addr, data) = (0,3), (1,5), (2,11), (3,13); done follows 24 cycles after the first rd_en.
- F=2 with ARREDONDAMENTO_EN -> writes 4, 6, 12, 14.
- F=4 -> a single write (0,8), or 9 with the macro; the rd_addr sequence is 0..15.
- Backpressure: wr_ready low for 5 cycles at the second block -> wr_valid, wr_data=5 and wr_addr=1 stay stable, no rd_en occurs, and done arrives 5 cycles later.
- start pulsed while busy, and fator_sel toggled mid-frame -> output identical to the undisturbed run, with no second frame.
- rst asserted during LER of block 2, then a new start -> all outputs at reset values during reset; the new frame restarts at rd_addr=0 and wr_addr=0 with the correct means.
